// File: rtl/grid_line_clear_ctrl.sv
// grid_line_clear_ctrl: playfield cell grid with line-clear sweep and colour-mapper view.
// Ports: Clk, Reset (sync, active-high); clear_req, wr_en/wr_row/wr_col/wr_cell, lock_req,
//   vsync in; busy, done, lines_cleared, total_lines, grid_out out.
// Option: define GRID_SHADOW_EN to present grid_out as a vsync-loaded shadow copy.
module grid_line_clear_ctrl #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                clear_req,
    input  logic                                wr_en,
    input  logic [4:0]                          wr_row,
    input  logic [3:0]                          wr_col,
    input  logic [CW-1:0]                       wr_cell,
    input  logic                                lock_req,
    input  logic                                vsync,
    output logic                                busy,
    output logic                                done,
    output logic [4:0]                          lines_cleared,
    output logic [15:0]                         total_lines,
    output logic [ROWS-1:0][COLS-1:0][CW-1:0]   grid_out
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } state_t;

    localparam logic [4:0] ROWS_L = 5'(ROWS);
    localparam logic [3:0] COLS_L = 4'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t state;
    logic [ROWS-1:0][COLS-1:0][CW-1:0] grid;
    logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_next;
    logic [4:0] r;
    logic [4:0] count;
    logic       row_full;
    logic       wr_ok;
    logic [16:0] sum;

    // Grid as it will look after an IDLE cycle (clear wins over the write).
    always_comb begin
        wr_ok = wr_en && (wr_row < ROWS_L) && (wr_col < COLS_L);
        grid_next = grid;
        if (clear_req) begin
            grid_next = '0;
        end else if (wr_ok) begin
            grid_next[wr_row][wr_col] = wr_cell;
        end
    end

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (grid[r][c] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    assign sum = {1'b0, total_lines} + {12'd0, count};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            grid          <= '0;
            r             <= '0;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    grid <= grid_next;
                    if (clear_req) begin
                        total_lines <= '0;
                    end else if (lock_req) begin
                        r     <= LAST_ROW;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state <= SHIFT;
                    end else if (r == 5'd0) begin
                        state <= DONE;
                    end else begin
                        r <= r - 5'd1;
                    end
                end
                SHIFT: begin
                    // Drop everything above row r by one; r is rescanned next.
                    for (int k = 1; k < ROWS; k++) begin
                        if (k <= int'(r)) begin
                            grid[k] <= grid[k-1];
                        end
                    end
                    grid[0] <= '0;
                    count   <= count + 5'd1;
                    state   <= SCAN;
                end
                DONE: begin
                    done          <= 1'b1;
                    lines_cleared <= count;
                    total_lines   <= sum[16] ? 16'hFFFF : sum[15:0];
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef GRID_SHADOW_EN
    // Only refreshed from IDLE so a half-finished sweep is never displayed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grid_out <= '0;
        end else if (state == IDLE && vsync) begin
            grid_out <= grid_next;
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign grid_out = grid;
`endif

endmodule

// File: tb/tb_grid_line_clear_ctrl.sv
// tb_grid_line_clear_ctrl: directed and randomized bench for grid_line_clear_ctrl,
// checked every cycle against a row-compaction reference model.
module tb_grid_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 3;

    logic Clk = 1'b0;
    logic Reset, clear_req, wr_en, lock_req, vsync;
    logic [4:0] wr_row;
    logic [3:0] wr_col;
    logic [CW-1:0] wr_cell;
    logic busy, done;
    logic [4:0] lines_cleared;
    logic [15:0] total_lines;
    logic [ROWS-1:0][COLS-1:0][CW-1:0] grid_out;

    grid_line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .clear_req(clear_req), .wr_en(wr_en),
        .wr_row(wr_row), .wr_col(wr_col), .wr_cell(wr_cell),
        .lock_req(lock_req), .vsync(vsync), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines),
        .grid_out(grid_out)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a lock removes every full row at once and packs the
    // remaining rows to the bottom; the result appears after the sweep time.
    int mg[ROWS][COLS];
    int msh[ROWS][COLS];
    int nb[ROWS][COLS];
    int m_rem = 0;
    int m_cnt = 0;
    int m_lc = 0;
    int m_total = 0;
    bit m_done = 0;

    function automatic bit m_full(input int row);
        for (int c = 0; c < COLS; c++)
            if (mg[row][c] == 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge Clk) begin
        cyc++;
        if (Reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    mg[r][c] = 0;
                    msh[r][c] = 0;
                end
            m_rem = 0; m_done = 0; m_lc = 0; m_total = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = 0;
            if (m_rem == 0) begin
                m_done = 1;
                m_lc = m_cnt;
                m_total = (m_total + m_cnt > 65535) ? 65535 : m_total + m_cnt;
            end
        end else begin
            m_done = 0;
            if (clear_req) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) mg[r][c] = 0;
                m_total = 0;
            end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
                mg[wr_row][wr_col] = int'(wr_cell);
            end
            if (vsync)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) msh[r][c] = mg[r][c];
            if (!clear_req && lock_req) begin
                int w;
                w = ROWS - 1;
                m_cnt = 0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) nb[r][c] = 0;
                for (int r = ROWS - 1; r >= 0; r--) begin
                    if (m_full(r)) begin
                        m_cnt++;
                    end else begin
                        for (int c = 0; c < COLS; c++) nb[w][c] = mg[r][c];
                        w--;
                    end
                end
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) mg[r][c] = nb[r][c];
                m_rem = ROWS + 1 + 2 * m_cnt;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        if (cyc > 0) begin
            int bad;
            int br;
            int bc;
            chk("busy", int'(busy), (m_rem > 0) ? 1 : 0);
            chk("done", int'(done), int'(m_done));
            chk("lines_cleared", int'(lines_cleared), m_lc);
            chk("total_lines", int'(total_lines), m_total);
            bad = 0; br = 0; bc = 0;
`ifdef GRID_SHADOW_EN
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (int'(grid_out[r][c]) != msh[r][c] && bad == 0) begin
                        bad = 1; br = r; bc = c;
                    end
            if (bad != 0)
                chk($sformatf("grid_out[%0d][%0d]", br, bc), int'(grid_out[br][bc]), msh[br][bc]);
            else
                checks++;
`else
            if (m_rem == 0) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (int'(grid_out[r][c]) != mg[r][c] && bad == 0) begin
                            bad = 1; br = r; bc = c;
                        end
                if (bad != 0)
                    chk($sformatf("grid_out[%0d][%0d]", br, bc), int'(grid_out[br][bc]), mg[br][bc]);
                else
                    checks++;
            end
`endif
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic zero_inputs();
        clear_req = 0; wr_en = 0; lock_req = 0; vsync = 0;
        wr_row = 0; wr_col = 0; wr_cell = 0;
    endtask

    task automatic do_reset();
        Reset = 1; step(); Reset = 0;
    endtask

    task automatic do_write(input int r, input int c, input int v);
        wr_en = 1; wr_row = 5'(r); wr_col = 4'(c); wr_cell = CW'(v);
        step();
        wr_en = 0;
    endtask

    task automatic do_vsync();
        vsync = 1; step(); vsync = 0;
    endtask

    task automatic fill_row(input int r);
        for (int c = 0; c < COLS; c++) do_write(r, c, 1 + ((r * 3 + c) % 7));
    endtask

    // Lock and wait for done; returns edges from lock sample to done, -1 on timeout.
    task automatic lock_wait(input int poke_at, output int lat);
        int t;
        t = cyc + 1;
        lock_req = 1; step(); lock_req = 0;
        lat = -1;
        for (int i = 1; i < 120; i++) begin
            if (i == poke_at) begin
                lock_req = 1; wr_en = 1; wr_row = 0; wr_col = 0; wr_cell = 7;
            end
            step();
            lock_req = 0; wr_en = 0;
            if (done) begin
                lat = cyc - t;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    function automatic int nonzero_cells();
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (grid_out[r][c] != '0) n++;
        return n;
    endfunction

    task automatic watch_no_done(input string name, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done) pulses++;
        end
        chk(name, pulses, 0);
    endtask

    initial begin
        int lat;
        zero_inputs();
        Reset = 1;
        step(); step();
        Reset = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_total", int'(total_lines), 0);
        chk("rst_lc", int'(lines_cleared), 0);
        chk("rst_grid", nonzero_cells(), 0);

        // One full row under a lone block.
        for (int c = 0; c < COLS; c++) do_write(19, c, 3);
        do_write(18, 4, 5);
        lock_wait(0, lat);
        chk("t1_latency", lat, 23);
        chk("t1_lc", int'(lines_cleared), 1);
        chk("t1_total", int'(total_lines), 1);
        do_vsync();
        chk("t1_r19c4", int'(grid_out[19][4]), 5);
        chk("t1_r19c0", int'(grid_out[19][0]), 0);
        chk("t1_r18c4", int'(grid_out[18][4]), 0);
        chk("t1_cells", nonzero_cells(), 1);

        // Four full rows.
        do_reset();
        for (int r = 16; r < 20; r++) fill_row(r);
        do_write(15, 2, 1);
        lock_wait(0, lat);
        chk("t2_latency", lat, 29);
        chk("t2_lc", int'(lines_cleared), 4);
        chk("t2_total", int'(total_lines), 4);
        do_vsync();
        chk("t2_r19c2", int'(grid_out[19][2]), 1);
        chk("t2_cells", nonzero_cells(), 1);

        // Clear has priority over lock and write.
        clear_req = 1; lock_req = 1; wr_en = 1; wr_row = 0; wr_col = 0; wr_cell = 7;
        vsync = 1;
        step();
        zero_inputs();
        chk("t4_busy", int'(busy), 0);
        chk("t4_total", int'(total_lines), 0);
        chk("t4_cells", nonzero_cells(), 0);
        do_write(25, 3, 6);
        do_write(2, 12, 6);
        do_vsync();
        chk("t4_oob_cells", nonzero_cells(), 0);

        // Empty sweep; lock and write during busy are dropped.
        lock_wait(5, lat);
        chk("t3_latency", lat, 21);
        chk("t3_lc", int'(lines_cleared), 0);
        chk("t3_total", int'(total_lines), 0);
        watch_no_done("t3_no_second_done", 30);
        do_vsync();
        chk("t3_cells", nonzero_cells(), 0);

        // Entire grid full.
        for (int r = 0; r < ROWS; r++) fill_row(r);
        lock_wait(0, lat);
        chk("t7_latency", lat, 61);
        chk("t7_lc", int'(lines_cleared), 20);
        chk("t7_total", int'(total_lines), 20);
        do_vsync();
        chk("t7_cells", nonzero_cells(), 0);

        // Reset in the middle of a sweep.
        fill_row(19);
        do_write(10, 1, 2);
        lock_req = 1; step(); lock_req = 0;
        repeat (9) step();
        Reset = 1; step(); Reset = 0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_total", int'(total_lines), 0);
        chk("t5_cells", nonzero_cells(), 0);
        watch_no_done("t5_no_done", 40);

`ifdef GRID_SHADOW_EN
        do_write(5, 5, 2);
        chk("t6_before_vsync", int'(grid_out[5][5]), 0);
        do_vsync();
        chk("t6_after_vsync", int'(grid_out[5][5]), 2);
        fill_row(19);
        lock_req = 1; step(); lock_req = 0;
        repeat (3) step();
        do_vsync();
        chk("t6_busy_vsync_r19", int'(grid_out[19][0]), 0);
        repeat (30) step();
        chk("t6_stale_r5", int'(grid_out[5][5]), 2);
        do_vsync();
        chk("t6_new_r6", int'(grid_out[6][5]), 2);
        chk("t6_new_r5", int'(grid_out[5][5]), 0);
`endif

        // Randomized traffic; the per-cycle compare does the checking.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            wr_en = ($urandom_range(0, 9) < 7);
            wr_row = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 25))
                                                 : 5'($urandom_range(13, 19));
            wr_col = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 9));
            wr_cell = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom_range(1, 7));
            lock_req = ($urandom_range(0, 24) == 0);
            clear_req = ($urandom_range(0, 299) == 0);
            vsync = ($urandom_range(0, 5) == 0);
            Reset = ($urandom_range(0, 799) == 0);
            step();
        end
        zero_inputs();
        Reset = 0;
        repeat (80) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
